last_deq_vt_cache: RTL and testbench
====================================

# last_deq_vt_cache

Direct-mapped cache of the last dequeued virtual time (VT = {ts, tiebreaker}) per object, sitting inside the commit queue on each tile's task-dequeue path. For each dequeuing task it reports whether the task's VT is strictly greater than the last VT dequeued for the same object, which lets the commit queue skip the full conflict check. The cache is sized by the package constant LOG_LAST_DEQ_VT_CACHE and is cleared by a sweeping flush on reset and on abort/rollback.

## Interface
- LOG_ENTRIES, default LOG_LAST_DEQ_VT_CACHE (9): log2 of entry count; legal range ≥4.
- OBJECT_WIDTH, default 32: object id width.
- TS_WIDTH, default 32: timestamp width.
- TB_WIDTH, default 32: tiebreaker width. VT width = TS_WIDTH+TB_WIDTH.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- lookup_valid  in  1  lookup request.
- lookup_ready  out  1  lookup accepted when valid&&ready; equals !busy.
- lookup_object  in  OBJECT_WIDTH  object of the dequeuing task.
- lookup_vt  in  VT  VT of the dequeuing task.
- resp_valid  out  1  one-cycle pulse, one cycle after each accepted lookup.
- resp_hit  out  1  valid entry with matching tag.
- resp_bypass  out  1  resp_hit && lookup_vt > stored VT.
- upd_valid  in  1  dequeue commit; no backpressure.
- upd_object  in  OBJECT_WIDTH  object of the dequeued task.
- upd_vt  in  VT  VT of the dequeued task.
- flush  in  1  single-cycle request to invalidate all entries.
- busy  out  1  flush sweep in progress.

## Operation
- Index = object[LOG_ENTRIES-1:0]. Tag = object[OBJECT_WIDTH-1:LOG_ENTRIES]. Each entry holds {valid, tag, vt}.
- Update on a tag match with a valid entry: store max(stored vt, upd_vt). Otherwise replace the entry with {1, tag, upd_vt}.
- Updates presented while busy, or in the cycle flush is asserted, are dropped.
- VT compare is unsigned on the concatenation {ts, tb}.
- State machine IDLE/FLUSH:
  - rst or flush in any state → FLUSH, with the sweep counter at 0.
  - FLUSH writes valid=0 to entry[counter] and increments the counter each cycle.
  - After writing entry 2^LOG_ENTRIES−1 → IDLE.
  - flush asserted while already in FLUSH restarts the counter at 0.
- Forwarding: a lookup and an update to the same index in the same cycle must see the updated entry (the post-max value).
- A lookup accepted in the same cycle flush is asserted responds with hit=0, bypass=0.
- An update in cycle t+1 does not affect the response to a lookup accepted in cycle t.

## Timing
- Reset values: state=FLUSH, counter=0, busy=1, lookup_ready=0, resp_valid=0, resp_hit=0, resp_bypass=0.
- A full flush takes 2^LOG_ENTRIES cycles: busy is high for exactly 512 cycles after rst deasserts (default size).
- Lookup latency is 1 cycle; throughput is 1 lookup per cycle when not busy.
- resp_hit and resp_bypass are 0 whenever resp_valid=0.
- Update takes effect for lookups accepted in the same cycle (via forwarding) and in all later cycles.
- Equal VTs give bypass=0 (strictly greater is required).
- Index wrap-around: objects differing only in tag bits alias. A tag mismatch is a miss, never a bypass.

## Structure
- The shared package holds:
  - vt_t: packed {ts, tb}.
  - LOG_LAST_DEQ_VT_CACHE.
  - cache_entry_t: {valid, tag, vt_t}.
- Sub-module sdp_ram: simple dual-port, one write port and one synchronous read port (1-cycle read).
  - The write port is muxed between flush sweep and update.
  - Update read-modify-write uses a second read port, or a duplicated sdp_ram instance, as needed.

## Test plan
- Reset, then hold lookup_valid: lookup_ready stays 0 for 512 cycles. First response is hit=0, bypass=0.
- upd(obj=0x25, vt={5,1}), then lookup(obj=0x25, vt={6,0}) → hit=1, bypass=1. Lookup with vt={5,1} → hit=1, bypass=0.
- upd(0x25,{9,0}) then upd(0x25,{3,0}), then lookup(0x25,{8,0}) → hit=1, bypass=0 (stored max is {9,0}).
- upd(0x25,{5,0}), then lookup(0x225,{9,0}) (same index, different tag) → hit=0, bypass=0.
- Same-cycle upd(0x40,{7,0}) and lookup(0x40,{8,0}) on an empty entry → hit=1, bypass=1 (forwarded).
- Populate 4 objects, pulse flush mid-stream, pulse flush again 100 cycles later → busy for 100+512 cycles. Afterwards all 4 lookups miss. Updates issued while busy are dropped.

Source files
------------

// File: rtl/last_deq_vt_cache_pkg.sv
// ============================================================================
// last_deq_vt_cache_pkg : shared types and sizing for the last-dequeued-VT cache
// Revision: 1.0
// ============================================================================
`default_nettype none

package last_deq_vt_cache_pkg;

  localparam int LOG_LAST_DEQ_VT_CACHE = 9;
  localparam int DEF_OBJECT_WIDTH      = 32;
  localparam int DEF_TS_WIDTH          = 32;
  localparam int DEF_TB_WIDTH          = 32;

  typedef struct packed {
    logic [DEF_TS_WIDTH-1:0] ts;
    logic [DEF_TB_WIDTH-1:0] tb;
  } vt_t;

  typedef struct packed {
    logic                                              valid;
    logic [DEF_OBJECT_WIDTH-LOG_LAST_DEQ_VT_CACHE-1:0] tag;
    vt_t                                               vt;
  } cache_entry_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/last_deq_vt_cache_if.sv
// ============================================================================
// last_deq_vt_cache_if : lookup / update / flush bundle of the last-deq-VT cache
// Revision: 1.0
// ============================================================================
`default_nettype none

interface last_deq_vt_cache_if #(
  parameter int OBJECT_WIDTH = 32,
  parameter int VT_WIDTH     = 64
);
  logic                    lookup_valid;
  logic                    lookup_ready;
  logic [OBJECT_WIDTH-1:0] lookup_object;
  logic [VT_WIDTH-1:0]     lookup_vt;
  logic                    resp_valid;
  logic                    resp_hit;
  logic                    resp_bypass;
  logic                    upd_valid;
  logic [OBJECT_WIDTH-1:0] upd_object;
  logic [VT_WIDTH-1:0]     upd_vt;
  logic                    flush;
  logic                    busy;

  modport master (
    output lookup_valid, lookup_object, lookup_vt,
    output upd_valid, upd_object, upd_vt, flush,
    input  lookup_ready, resp_valid, resp_hit, resp_bypass, busy
  );

  modport slave (
    input  lookup_valid, lookup_object, lookup_vt,
    input  upd_valid, upd_object, upd_vt, flush,
    output lookup_ready, resp_valid, resp_hit, resp_bypass, busy
  );
endinterface

`default_nettype wire

// File: rtl/last_deq_vt_cache_sdp_ram.sv
// ============================================================================
// last_deq_vt_cache_sdp_ram : one write port, one read-first synchronous read port
// Revision: 1.0
// ============================================================================
`default_nettype none

module last_deq_vt_cache_sdp_ram #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64
) (
  input  wire logic                  clk,
  input  wire logic                  we,
  input  wire logic [ADDR_WIDTH-1:0] waddr,
  input  wire logic [DATA_WIDTH-1:0] wdata,
  input  wire logic [ADDR_WIDTH-1:0] raddr,
  output      logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [1<<ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/last_deq_vt_cache.sv
// ============================================================================
// last_deq_vt_cache : direct-mapped cache of the last dequeued VT per object
// Revision: 1.0
// ============================================================================
`default_nettype none

module last_deq_vt_cache
  import last_deq_vt_cache_pkg::*;
#(
  parameter int LOG_ENTRIES  = LOG_LAST_DEQ_VT_CACHE,
  parameter int OBJECT_WIDTH = 32,
  parameter int TS_WIDTH     = 32,
  parameter int TB_WIDTH     = 32
) (
  input wire logic            clk,
  input wire logic            rst,
  last_deq_vt_cache_if.slave  bus
);

  localparam int VT_W    = TS_WIDTH + TB_WIDTH;
  localparam int TAG_W   = OBJECT_WIDTH - LOG_ENTRIES;
  localparam int ENTRY_W = 1 + TAG_W + VT_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [VT_W-1:0]  vt;
  } entry_t;

  state_t                 state, state_nxt;
  logic [LOG_ENTRIES-1:0] sweep_cnt, sweep_cnt_nxt;
  logic                   busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FLUSH;
      sweep_cnt <= '0;
    end else begin
      state     <= state_nxt;
      sweep_cnt <= sweep_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sweep_cnt_nxt = sweep_cnt;
    if (bus.flush) begin
      state_nxt     = ST_FLUSH;
      sweep_cnt_nxt = '0;
    end else if (state == ST_FLUSH) begin
      sweep_cnt_nxt = sweep_cnt + 1'b1;
      if (&sweep_cnt) begin
        state_nxt = ST_IDLE;
      end
    end
  end

  assign busy = (state == ST_FLUSH);

  logic lookup_fire, upd_accept;
  assign lookup_fire = bus.lookup_valid && !busy;
  assign upd_accept  = bus.upd_valid && !busy && !bus.flush;

  logic                   lk_valid, lk_kill;
  logic [LOG_ENTRIES-1:0] lk_idx;
  logic [TAG_W-1:0]       lk_tag;
  logic [VT_W-1:0]        lk_vt;
  logic                   up_valid;
  logic [LOG_ENTRIES-1:0] up_idx;
  logic [TAG_W-1:0]       up_tag;
  logic [VT_W-1:0]        up_vt;
  logic                   wr_en, wr_en_q;
  logic [LOG_ENTRIES-1:0] wr_idx, wr_idx_q;
  entry_t                 wr_data, wr_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lk_valid <= 1'b0;
      up_valid <= 1'b0;
      wr_en_q  <= 1'b0;
    end else begin
      lk_valid <= lookup_fire;
      up_valid <= upd_accept;
      wr_en_q  <= wr_en;
    end
    lk_kill   <= bus.flush;
    lk_idx    <= bus.lookup_object[LOG_ENTRIES-1:0];
    lk_tag    <= bus.lookup_object[OBJECT_WIDTH-1:LOG_ENTRIES];
    lk_vt     <= bus.lookup_vt;
    up_idx    <= bus.upd_object[LOG_ENTRIES-1:0];
    up_tag    <= bus.upd_object[OBJECT_WIDTH-1:LOG_ENTRIES];
    up_vt     <= bus.upd_vt;
    wr_idx_q  <= wr_idx;
    wr_data_q <= wr_data;
  end

  // Port 0 serves lookups, port 1 the update read-modify-write; both share the write port.
  logic [LOG_ENTRIES-1:0] rd_addr [2];
  logic [ENTRY_W-1:0]     rd_data [2];

  assign rd_addr[0] = bus.lookup_object[LOG_ENTRIES-1:0];
  assign rd_addr[1] = bus.upd_object[LOG_ENTRIES-1:0];

  genvar p;
  generate
    for (p = 0; p < 2; p++) begin : g_rd_port
      last_deq_vt_cache_sdp_ram #(
        .ADDR_WIDTH (LOG_ENTRIES),
        .DATA_WIDTH (ENTRY_W)
      ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_idx),
        .wdata (wr_data),
        .raddr (rd_addr[p]),
        .rdata (rd_data[p])
      );
    end
  endgenerate

  // The RAM reads old data, so the write landing in the read cycle is patched in here.
  entry_t lk_raw, up_cur, upd_entry, lk_entry;
  always_comb begin
    lk_raw = (wr_en_q && wr_idx_q == lk_idx) ? wr_data_q : entry_t'(rd_data[0]);
    up_cur = (wr_en_q && wr_idx_q == up_idx) ? wr_data_q : entry_t'(rd_data[1]);

    upd_entry.valid = 1'b1;
    upd_entry.tag   = up_tag;
    upd_entry.vt    = up_vt;
    if (up_cur.valid && up_cur.tag == up_tag && up_cur.vt > up_vt) begin
      upd_entry.vt = up_cur.vt;
    end

    lk_entry = (up_valid && up_idx == lk_idx) ? upd_entry : lk_raw;
  end

  always_comb begin
    wr_en   = up_valid;
    wr_idx  = up_idx;
    wr_data = upd_entry;
    if (busy) begin
      wr_en   = 1'b1;
      wr_idx  = sweep_cnt;
      wr_data = '0;
    end
  end

  logic hit;
  assign hit = lk_valid && !lk_kill && lk_entry.valid && (lk_entry.tag == lk_tag);

  assign bus.lookup_ready = !busy;
  assign bus.busy         = busy;
  assign bus.resp_valid   = lk_valid;
  assign bus.resp_hit     = hit;
  assign bus.resp_bypass  = hit && (lk_vt > lk_entry.vt);

endmodule

`default_nettype wire

// File: tb/tb_last_deq_vt_cache.sv
// ============================================================================
// tb_last_deq_vt_cache : directed scoreboard bench for last_deq_vt_cache
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_last_deq_vt_cache;
  import last_deq_vt_cache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  last_deq_vt_cache_if #(.OBJECT_WIDTH(32), .VT_WIDTH(64)) bus ();

  last_deq_vt_cache #(
    .LOG_ENTRIES  (9),
    .OBJECT_WIDTH (32),
    .TS_WIDTH     (32),
    .TB_WIDTH     (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic  hit;
    logic  byp;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic vt_t mk_vt(input int unsigned ts, input int unsigned tb);
    vt_t v;
    v.ts = ts;
    v.tb = tb;
    return v;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.resp_valid) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $error("FAIL unexpected_resp observed resp_valid=1 expected no response");
      end else begin
        e = sb.pop_front();
        assert ({bus.resp_hit, bus.resp_bypass} === {e.hit, e.byp})
        else begin
          miscompares++;
          $error("FAIL %s observed hit/bypass=%b%b expected %b%b",
                 e.tag, bus.resp_hit, bus.resp_bypass, e.hit, e.byp);
        end
      end
    end else if (!rst) begin
      vectors++;
      assert ({bus.resp_hit, bus.resp_bypass} === 2'b00)
      else begin
        miscompares++;
        $error("FAIL idle_outputs observed hit/bypass=%b%b expected 00",
               bus.resp_hit, bus.resp_bypass);
      end
    end
  end

  task automatic push(input logic h, input logic b, input string t);
    exp_t e;
    e.hit = h;
    e.byp = b;
    e.tag = t;
    sb.push_back(e);
  endtask

  task automatic lookup(input logic [31:0] obj, input vt_t v,
                        input logic h, input logic b, input string t);
    bus.lookup_valid  = 1'b1;
    bus.lookup_object = obj;
    bus.lookup_vt     = v;
    push(h, b, t);
    @(negedge clk);
    bus.lookup_valid = 1'b0;
  endtask

  task automatic update(input logic [31:0] obj, input vt_t v);
    bus.upd_valid  = 1'b1;
    bus.upd_object = obj;
    bus.upd_vt     = v;
    @(negedge clk);
    bus.upd_valid = 1'b0;
  endtask

  task automatic check_bit(input logic obs, input logic exp, input string t);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed %b expected %b", t, obs, exp);
    end
  endtask

  task automatic check_int(input int obs, input int exp, input string t);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed %0d expected %0d", t, obs, exp);
    end
  endtask

  initial begin
    int n;
    rst               = 1'b1;
    bus.lookup_valid  = 1'b0;
    bus.lookup_object = '0;
    bus.lookup_vt     = '0;
    bus.upd_valid     = 1'b0;
    bus.upd_object    = '0;
    bus.upd_vt        = '0;
    bus.flush         = 1'b0;
    repeat (3) @(negedge clk);

    check_bit(bus.busy, 1'b1, "rst_busy");
    check_bit(bus.lookup_ready, 1'b0, "rst_ready");
    check_bit(bus.resp_valid, 1'b0, "rst_resp_valid");
    check_bit(bus.resp_hit, 1'b0, "rst_resp_hit");
    check_bit(bus.resp_bypass, 1'b0, "rst_resp_bypass");

    // Hold a lookup across the whole post-reset sweep.
    rst               = 1'b0;
    bus.lookup_valid  = 1'b1;
    bus.lookup_object = 32'h25;
    bus.lookup_vt     = mk_vt(1, 0);
    n = 0;
    while (!bus.lookup_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_int(n, 512, "reset_busy_cycles");
    push(1'b0, 1'b0, "first_resp");
    @(negedge clk);
    bus.lookup_valid = 1'b0;

    update(32'h25, mk_vt(5, 1));
    lookup(32'h25, mk_vt(6, 0), 1'b1, 1'b1, "gt_bypass");
    lookup(32'h25, mk_vt(5, 1), 1'b1, 1'b0, "equal_vt");

    update(32'h25, mk_vt(9, 0));
    update(32'h25, mk_vt(3, 0));
    lookup(32'h25, mk_vt(8, 0), 1'b1, 1'b0, "max_kept");
    lookup(32'h25, mk_vt(9, 1), 1'b1, 1'b1, "max_tb_greater");

    update(32'h25, mk_vt(5, 0));
    lookup(32'h225, mk_vt(9, 0), 1'b0, 1'b0, "alias_miss");
    update(32'h225, mk_vt(1, 0));
    lookup(32'h225, mk_vt(2, 0), 1'b1, 1'b1, "alias_replace");
    lookup(32'h25, mk_vt(100, 0), 1'b0, 1'b0, "alias_evicted");

    // Same-cycle update and lookup on empty entries.
    bus.upd_valid  = 1'b1;
    bus.upd_object = 32'h40;
    bus.upd_vt     = mk_vt(7, 0);
    lookup(32'h40, mk_vt(8, 0), 1'b1, 1'b1, "fwd_bypass");
    bus.upd_valid  = 1'b1;
    bus.upd_object = 32'h41;
    bus.upd_vt     = mk_vt(7, 0);
    lookup(32'h41, mk_vt(7, 0), 1'b1, 1'b0, "fwd_equal");
    bus.upd_valid = 1'b0;

    // An update one cycle after a lookup must not affect it.
    bus.lookup_valid  = 1'b1;
    bus.lookup_object = 32'h50;
    bus.lookup_vt     = mk_vt(1, 0);
    push(1'b0, 1'b0, "late_update");
    @(negedge clk);
    bus.lookup_valid = 1'b0;
    update(32'h50, mk_vt(0, 0));
    lookup(32'h50, mk_vt(1, 0), 1'b1, 1'b1, "late_update_applied");

    update(32'h100, mk_vt(10, 0));
    update(32'h101, mk_vt(10, 0));
    update(32'h1FF, mk_vt(10, 0));
    update(32'h3,   mk_vt(10, 0));
    lookup(32'h100, mk_vt(11, 0), 1'b1, 1'b1, "pop_0x100");
    lookup(32'h101, mk_vt(11, 0), 1'b1, 1'b1, "pop_0x101");
    lookup(32'h1FF, mk_vt(11, 0), 1'b1, 1'b1, "pop_0x1ff");
    lookup(32'h3,   mk_vt(11, 0), 1'b1, 1'b1, "pop_0x3");

    // Flush with a lookup in the same cycle, re-flush 100 cycles later.
    bus.flush = 1'b1;
    lookup(32'h100, mk_vt(11, 0), 1'b0, 1'b0, "flush_same_cycle");
    bus.flush = 1'b0;
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!bus.busy) break;
      n++;
      bus.flush      = (n == 100);
      bus.upd_valid  = (n == 50) || (n == 612);
      bus.upd_object = 32'h101;
      bus.upd_vt     = mk_vt(1, 0);
      @(negedge clk);
    end
    bus.flush     = 1'b0;
    bus.upd_valid = 1'b0;
    check_int(n, 612, "reflush_busy_cycles");

    lookup(32'h100, mk_vt(11, 0), 1'b0, 1'b0, "flushed_0x100");
    lookup(32'h101, mk_vt(11, 0), 1'b0, 1'b0, "flushed_0x101");
    lookup(32'h1FF, mk_vt(11, 0), 1'b0, 1'b0, "flushed_0x1ff");
    lookup(32'h3,   mk_vt(11, 0), 1'b0, 1'b0, "flushed_0x3");
    update(32'h3, mk_vt(4, 0));
    lookup(32'h3, mk_vt(4, 0), 1'b1, 1'b0, "post_flush_equal");

    repeat (3) @(negedge clk);
    check_int(sb.size(), 0, "scoreboard_drained");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
